// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants, state encoding and saturation helper for the frequency BCD path
package freq_pkg;

  localparam int BCD_BITS = 4;
  localparam logic [BCD_BITS-1:0] BCD_NINE = 4'h9;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Largest value representable in n decimal digits; 64 bits covers any practical digit count
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - combinational add-3 correction for one BCD digit ahead of a shift
module bcd_digit_adjust
  import freq_pkg::*;
(
  input  logic [BCD_BITS-1:0] digit_in,
  output logic [BCD_BITS-1:0] digit_out
);

  // A digit of 5 or more would carry past 9 after doubling, so pre-bias it by 3
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/freq_bin2bcd.sv
// rtl/freq_bin2bcd.sv - sequential double-dabble binary to packed BCD converter; optional FREQ_BCD_AUTO_REFRESH_EN
module freq_bin2bcd
  import freq_pkg::*;
#(
  parameter int BIN_WIDTH  = 20,
  parameter int BCD_DIGITS = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BIN_WIDTH-1:0]             bin_freq,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [BCD_DIGITS*BCD_BITS-1:0]   bcd_freq,
  output logic                             overflow
);

  localparam int SCR_W = BCD_DIGITS * BCD_BITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [63:0] SAT_LIMIT = pow10_minus1(BCD_DIGITS);
  localparam logic [SCR_W-1:0] ALL_NINES = {BCD_DIGITS{BCD_NINE}};

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [SCR_W-1:0]     scratch_q;
  logic [SCR_W-1:0]     scratch_adj;
  logic [SCR_W-1:0]     scratch_next;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ovf_q;
  logic                 ovf_in;
  logic                 go;

  // Narrow inputs can never exceed the limit, so this folds to constant 0 for them
  assign ovf_in = (64'(bin_freq) > SAT_LIMIT);

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (scratch_q[d*BCD_BITS +: BCD_BITS]),
      .digit_out (scratch_adj[d*BCD_BITS +: BCD_BITS])
    );
  end

  // Carry out of the top digit is dropped; saturation covers every case where it matters
  assign scratch_next = (scratch_adj << 1) | SCR_W'(shift_q[BIN_WIDTH-1]);

  assign busy = (state == CONVERT);

`ifdef FREQ_BCD_AUTO_REFRESH_EN
  logic [BIN_WIDTH-1:0] last_bin;

  assign go = start || (bin_freq != last_bin);

  // Remember the value captured by the most recent conversion so only changes retrigger
  always_ff @(posedge clk) begin
    if (reset) begin
      last_bin <= '0;
    end else if ((state == IDLE) && go) begin
      last_bin <= bin_freq;
    end
  end
`else
  assign go = start;
`endif

  // Conversion FSM: capture in IDLE, one adjust-and-shift per cycle in CONVERT, publish on the last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bit_cnt   <= '0;
      ovf_q     <= 1'b0;
      done      <= 1'b0;
      bcd_freq  <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            shift_q   <= bin_freq;
            scratch_q <= '0;
            bit_cnt   <= CNT_INIT;
            ovf_q     <= ovf_in;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_q <= scratch_next;
          shift_q   <= shift_q << 1;
          bit_cnt   <= bit_cnt - CNT_ONE;
          if (bit_cnt == '0) begin
            bcd_freq <= ovf_q ? ALL_NINES : scratch_next;
            overflow <= ovf_q;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
